// File: rtl/fetch_memory_responder.sv
// fetch_memory_responder
//   Memory-side responder for the fetch stage's instruction port. A single-entry
//   word buffer serves repeated fetches of the same pc with zero latency. A miss
//   fills the buffer with two halfword reads, low half first, over a 16-bit
//   memory bus that has a wait-request. A fill that fetch no longer wants (the
//   address changed, fetch dropped its request, or an invalidate arrived) is
//   marked stale. The fill then finishes any read already issued on the bus and
//   discards the returned data.
//
// Ports
//   clock, reset_n      single clock; asynchronous active-low reset
//   address_enable      fetch requests the word at address this cycle
//   address[31:0]       fetch byte address, bits [1:0] ignored
//   data_valid          data holds the word at address (combinational)
//   data[31:0]          buffered instruction word (registered)
//   invalidate          drop the buffer contents and any in-flight fill
//   mem_read            read request, held until accepted (registered)
//   mem_address[31:0]   halfword byte address of the request (registered)
//   mem_waitrequest     memory is stalling the current request
//   mem_readdatavalid   mem_readdata is valid
//   mem_readdata[15:0]  returned halfword
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no read in flight; a miss launches the low-half read
// LOW_REQ   | low-half read asserted, waiting for acceptance
// LOW_WAIT  | low-half read accepted, waiting for its data
// HIGH_REQ  | high-half read asserted, waiting for acceptance
// HIGH_WAIT | high-half read accepted, waiting for its data; fills buffer
module fetch_memory_responder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        address_enable,
  input  logic [31:0] address,
  output logic        data_valid,
  output logic [31:0] data,
  input  logic        invalidate,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [15:0] mem_readdata
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOW_REQ   = 3'd1,
    LOW_WAIT  = 3'd2,
    HIGH_REQ  = 3'd3,
    HIGH_WAIT = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic        buf_valid;
  logic [29:0] buf_tag;
  logic [29:0] req_tag;
  logic        stale;
  logic [15:0] low;

  logic hit, miss, launch, stale_cond, stale_eff;
  logic addr_lsb_unused;

  assign addr_lsb_unused = ^address[1:0];

  assign hit        = buf_valid && (address[31:2] == buf_tag);
  assign miss       = address_enable && !hit;
  assign launch     = (state == IDLE) && miss && !invalidate;
  assign stale_cond = !address_enable || (address[31:2] != req_tag) || invalidate;
  // Include this cycle's condition so that a data beat arriving in the same
  // cycle as an abort is already discarded.
  assign stale_eff  = stale || stale_cond;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (launch)             state_nx = LOW_REQ;
      LOW_REQ:   if (!mem_waitrequest)   state_nx = LOW_WAIT;
      LOW_WAIT:  if (mem_readdatavalid)  state_nx = stale_eff ? IDLE : HIGH_REQ;
      HIGH_REQ:  if (!mem_waitrequest)   state_nx = HIGH_WAIT;
      HIGH_WAIT: if (mem_readdatavalid)  state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_read    <= 1'b0;
      mem_address <= 32'd0;
      req_tag     <= 30'd0;
      stale       <= 1'b0;
      low         <= 16'd0;
      buf_valid   <= 1'b0;
      buf_tag     <= 30'd0;
      data        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            req_tag     <= address[31:2];
            mem_address <= {address[31:2], 2'b00};
            mem_read    <= 1'b1;
            stale       <= 1'b0;
          end
        end
        LOW_REQ: begin
          if (!mem_waitrequest) mem_read <= 1'b0;
        end
        LOW_WAIT: begin
          if (mem_readdatavalid) begin
            low <= mem_readdata;
            if (!stale_eff) begin
              mem_address <= mem_address + 32'd2;
              mem_read    <= 1'b1;
            end
          end
        end
        HIGH_REQ: begin
          if (!mem_waitrequest) mem_read <= 1'b0;
        end
        HIGH_WAIT: begin
          if (mem_readdatavalid && !stale_eff) begin
            data      <= {mem_readdata, low};
            buf_tag   <= req_tag;
            buf_valid <= 1'b1;
          end
        end
        default: ;
      endcase
      // Once set, stale stays set for the rest of the fill; only a new launch clears it.
      if (state != IDLE && stale_cond) stale <= 1'b1;
      if (invalidate) buf_valid <= 1'b0;
    end
  end

  always_comb begin
    data_valid = buf_valid && address_enable && (address[31:2] == buf_tag);
  end

endmodule

// File: tb/tb_fetch_memory_responder.sv
module tb_fetch_memory_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        address_enable;
  logic [31:0] address;
  logic        invalidate;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic [15:0] mem_readdata;
  logic        data_valid;
  logic [31:0] data;
  logic        mem_read;
  logic [31:0] mem_address;

  fetch_memory_responder dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .address_enable    (address_enable),
    .address           (address),
    .data_valid        (data_valid),
    .data              (data),
    .invalidate        (invalidate),
    .mem_read          (mem_read),
    .mem_address       (mem_address),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // memory model state
  bit          rand_mode  = 1'b0;
  int          wait_cfg   = 0;
  int          wait_left  = 0;
  int          resp_delay = 1;
  int          resp_cnt   = 0;
  logic [31:0] resp_addr  = 32'd0;
  bit          prev_hold  = 1'b0;
  bit          prev_read  = 1'b0;
  logic [31:0] prev_addr  = 32'd0;

  logic [31:0] log_addr[$];
  int          log_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // memory contents: two fixed halfwords, everything else a hash of the address
  function automatic logic [15:0] mem_half(input logic [31:0] a);
    if (a == 32'h100) return 16'h1234;
    if (a == 32'h102) return 16'hABCD;
    return a[16:1] ^ 16'hC3A5 ^ {a[8:1], a[16:9]} ^ a[31:16];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] al;
    al = {a[31:2], 2'b00};
    return {mem_half(al + 32'd2), mem_half(al)};
  endfunction

  function automatic logic [31:0] log_a(input int i);
    if (i < log_addr.size()) return log_addr[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int log_c(input int i);
    if (i < log_cyc.size()) return log_cyc[i];
    return -1;
  endfunction

  // One clock: at the falling edge check outputs, then drive the memory side.
  task automatic cycle();
    @(negedge clock);
    cyc++;
    if (reset_n) begin
      if (prev_hold) begin
        check_eq("hold_read", {31'd0, mem_read}, 32'd1);
        check_eq("hold_addr", mem_address, prev_addr);
      end
      if (!address_enable) check_eq("dv_no_enable", {31'd0, data_valid}, 32'd0);
      if (invalidate)      check_eq("dv_after_inval", {31'd0, data_valid}, 32'd0);
      if (data_valid)      check_eq("dv_data", data, mem_word(address));
      if (mem_read && !prev_read) begin
        log_addr.push_back(mem_address);
        log_cyc.push_back(cyc);
      end
    end
    mem_readdatavalid = 1'b0;
    mem_readdata      = 16'($urandom);
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = mem_half(resp_addr);
      end
    end
    prev_hold = 1'b0;
    if (reset_n && mem_read) begin
      if (wait_left > 0) begin
        mem_waitrequest = 1'b1;
        wait_left--;
        prev_hold = 1'b1;
      end else begin
        mem_waitrequest = 1'b0;
        check_eq("one_outstanding", 32'(resp_cnt), 32'd0);
        resp_cnt  = rand_mode ? int'($urandom_range(1, 3)) : resp_delay;
        resp_addr = mem_address;
        wait_left = rand_mode ? int'($urandom_range(0, 3)) : wait_cfg;
      end
    end else begin
      mem_waitrequest = rand_mode ? 1'($urandom % 2) : 1'b0;
    end
    prev_read = reset_n && mem_read;
    prev_addr = mem_address;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; address_enable = 1'b0; address = 32'd0; invalidate = 1'b0;
    resp_cnt = 0; wait_left = wait_cfg; prev_hold = 1'b0; prev_read = 1'b0;
    cycle();
    cycle();
    check_eq("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check_eq("rst_mem_addr", mem_address, 32'd0);
    check_eq("rst_data", data, 32'd0);
    check_eq("rst_dv", {31'd0, data_valid}, 32'd0);
    reset_n = 1'b1;
    cycle();
    log_addr.delete();
    log_cyc.delete();
  endtask

  // Present addr and report the cycle (relative to now) data_valid first rises; -1 on timeout.
  task automatic run_fill(input logic [31:0] addr, input int budget, output int first);
    int base;
    base = cyc;
    first = -1;
    address = addr;
    address_enable = 1'b1;
    for (int i = 0; i < budget && first < 0; i++) begin
      cycle();
      if (data_valid) first = cyc - base;
    end
  endtask

  initial begin
    int first;
    int base;
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = 16'd0;

    // idle after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("idle_mem_read", {31'd0, mem_read}, 32'd0);
      check_eq("idle_dv", {31'd0, data_valid}, 32'd0);
      check_eq("idle_data", data, 32'd0);
    end

    // basic fill, zero wait states
    base = cyc;
    run_fill(32'h100, 30, first);
    check_eq("fill_latency", 32'(first), 32'd5);
    check_eq("fill_data", data, 32'hABCD1234);
    check_eq("fill_nreq", 32'(log_addr.size()), 32'd2);
    check_eq("fill_lo_addr", log_a(0), 32'h100);
    check_eq("fill_lo_cyc", 32'(log_c(0) - base), 32'd1);
    check_eq("fill_hi_addr", log_a(1), 32'h102);
    check_eq("fill_hi_cyc", 32'(log_c(1) - base), 32'd3);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_eq("hit_dv", {31'd0, data_valid}, 32'd1);
      check_eq("hit_no_read", {31'd0, mem_read}, 32'd0);
    end
    address = 32'h103;
    cycle();
    check_eq("hit_lsb_ignored", {31'd0, data_valid}, 32'd1);

    // three wait states on each half
    wait_cfg = 3;
    do_reset();
    run_fill(32'h100, 40, first);
    check_eq("wait_latency", 32'(first), 32'd11);
    check_eq("wait_nreq", 32'(log_addr.size()), 32'd2);
    check_eq("wait_hi_addr", log_a(1), 32'h102);
    wait_cfg = 0;

    // address change during LOW_REQ
    do_reset();
    base = cyc;
    address = 32'h100; address_enable = 1'b1;
    cycle();
    check_eq("chg_lowreq", {31'd0, mem_read}, 32'd1);
    address = 32'h200;
    first = -1;
    for (int i = 0; i < 30 && first < 0; i++) begin
      cycle();
      if (data_valid) first = cyc - base;
    end
    check_eq("chg_latency", 32'(first), 32'd8);
    check_eq("chg_nreq", 32'(log_addr.size()), 32'd3);
    check_eq("chg_first", log_a(0), 32'h100);
    check_eq("chg_relaunch", log_a(1), 32'h200);
    check_eq("chg_relaunch_cyc", 32'(log_c(1) - base), 32'd4);
    check_eq("chg_hi", log_a(2), 32'h202);
    check_eq("chg_data", data, mem_word(32'h200));

    // invalidate coinciding with the high-half data beat
    do_reset();
    address = 32'h300; address_enable = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    invalidate = 1'b1;
    cycle();
    check_eq("inval_no_write", {31'd0, data_valid}, 32'd0);
    invalidate = 1'b0;
    run_fill(32'h300, 30, first);
    check_eq("inval_refetch_lat", 32'(first), 32'd5);
    check_eq("inval_nreq", 32'(log_addr.size()), 32'd4);
    check_eq("inval_re_lo", log_a(2), 32'h300);
    check_eq("inval_re_hi", log_a(3), 32'h302);
    check_eq("inval_data", data, mem_word(32'h300));

    // reset during LOW_WAIT, data beat arrives after release
    do_reset();
    resp_delay = 3;
    address = 32'h100; address_enable = 1'b1;
    cycle();
    cycle();
    reset_n = 1'b0; address_enable = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("rstmid_no_read", {31'd0, mem_read}, 32'd0);
      check_eq("rstmid_dv", {31'd0, data_valid}, 32'd0);
    end
    resp_delay = 1;
    log_addr.delete(); log_cyc.delete();
    run_fill(32'h100, 30, first);
    check_eq("rstmid_refill_lat", 32'(first), 32'd5);
    check_eq("rstmid_nreq", 32'(log_addr.size()), 32'd2);
    check_eq("rstmid_data", data, 32'hABCD1234);

    // randomized traffic
    rand_mode = 1'b1;
    do_reset();
    for (int seg = 0; seg < 400; seg++) begin
      bit long_seg;
      int len;
      long_seg = ($urandom % 6) == 0;
      len = long_seg ? 40 : int'($urandom_range(1, 6));
      address = 32'h1000 + ($urandom_range(0, 15) << 2) + ($urandom % 4);
      address_enable = long_seg ? 1'b1 : (($urandom % 8) != 0);
      for (int i = 0; i < len; i++) begin
        invalidate = long_seg ? 1'b0 : (($urandom % 10) == 0);
        cycle();
      end
      if (long_seg) check_eq("rand_live", {31'd0, data_valid}, 32'd1);
    end
    invalidate = 1'b0;
    address_enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_memory_responder.md
# fetch_memory_responder

Memory-side responder for the fetch stage's instruction port: accepts the per-cycle fetch address, returns a 32-bit instruction word with a valid flag, and fills from a 16-bit external memory bus with wait-request. It sits between fetch and the external memory controller. A single-entry word buffer absorbs repeated fetches of the same pc, such as during holds. Stale or invalidated fills are aborted or discarded without violating the memory bus protocol.

## Interface
- Parameters: none; all datapaths 32 bits, memory data 16 bits.
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address_enable  in  1  fetch is requesting the word at `address` this cycle
- address  in  32  fetch byte address; bits [1:0] ignored
- data_valid  out  1  `data` is the word at `address` this cycle (combinational qualification)
- data  out  32  buffered instruction word (registered)
- invalidate  in  1  discard buffer contents and any in-flight fill (store to code space)
- mem_read  out  1  read request; held until accepted (registered)
- mem_address  out  32  byte address of requested halfword (registered)
- mem_waitrequest  in  1  memory not accepting; `mem_read`/`mem_address` must hold
- mem_readdatavalid  in  1  `mem_readdata` valid; at most one read outstanding
- mem_readdata  in  16  returned halfword

## Operation
- Buffer: `buf_valid`, `buf_tag[31:2]`, `buf_data[31:0]`; `data` = `buf_data`.
- `data_valid` = `buf_valid` && `address_enable` && (`address[31:2]` == `buf_tag`); no other path asserts it.
- Hit: `buf_valid` && tag match. Miss: `address_enable` && !hit.
- Request register `req_tag[31:2]`; flag `stale`; low-half register `low[15:0]`.
- FSM states and transitions:
  - IDLE: on miss && !`invalidate`, set `req_tag` = `address[31:2]`, `mem_address` = {`address[31:2]`,2'b00}, `mem_read` = 1, clear `stale`, go to LOW_REQ. `mem_readdatavalid` is ignored in IDLE.
  - LOW_REQ: when !`mem_waitrequest`, set `mem_read` = 0 and go to LOW_WAIT.
  - LOW_WAIT: on `mem_readdatavalid`, set `low` = `mem_readdata`.
    - If `stale`, go to IDLE.
    - Otherwise set `mem_address` += 2, `mem_read` = 1, and go to HIGH_REQ.
  - HIGH_REQ: when !`mem_waitrequest`, set `mem_read` = 0 and go to HIGH_WAIT.
  - HIGH_WAIT: on `mem_readdatavalid`, go to IDLE. If !`stale`, also set `buf_data` = {`mem_readdata`,`low`}, `buf_tag` = `req_tag`, `buf_valid` = 1.
- `stale` is set in any non-IDLE state on any of:
  - !`address_enable`,
  - `address[31:2]` != `req_tag`,
  - `invalidate`.
- `stale` is sticky until the next IDLE launch. A request is never withdrawn while `mem_read` is high and unaccepted.
- `invalidate` clears `buf_valid` at the next edge, in any state.
- Little-endian: low halfword at the lower address is fetched first.
- Reset values: `mem_read` 0, `mem_address` 0, `data` 0, `buf_valid` 0, state IDLE, `stale` 0, `low` 0, `req_tag` 0. Hence `data_valid` is 0.
- Reset mid-fill: the fill is abandoned. A late `mem_readdatavalid` is ignored because the FSM is in IDLE.

## Timing
- Hit: `data_valid` is high in the same cycle as the address; zero latency.
- Miss presented in cycle N, zero wait-states, `mem_readdatavalid` one cycle after acceptance:
  - `mem_read` high in N+1 (low half), LOW_WAIT in N+2, `mem_read` high in N+3 (high half), data in N+4.
  - `data_valid` high in N+5.
- Each wait-state cycle adds one cycle.
- Back-to-back misses: the next launch happens from IDLE in the cycle after HIGH_WAIT (or LOW_WAIT abort) completes, so `mem_read` is high two cycles after the final `mem_readdatavalid`.
- Address change during LOW_REQ: the low read completes, the FSM aborts at LOW_WAIT, and the new address launches from IDLE.
- `invalidate` in the same cycle as a HIGH_WAIT `mem_readdatavalid`: the buffer is not written and `buf_valid` = 0 afterwards.

## Test plan
- Reset, then hold `address_enable` = 0 → `mem_read` = 0, `data_valid` = 0, `data` = 0 throughout.
- Fetch 0x100; memory returns 0x1234 @0x100 and 0xABCD @0x102, no waits → `mem_read` in cycles 1 and 3 at addresses 0x100/0x102; `data` = 0xABCD1234 with `data_valid` = 1 in cycle 5. Holding 0x100 stays valid with no further `mem_read`.
- Same fetch with `mem_waitrequest` high for 3 cycles on each half → `mem_address` stable while waiting; `data_valid` in cycle 11.
- Address changes 0x100 → 0x200 during LOW_REQ → 0x100 low read completes, no high read for 0x100, next `mem_read` at 0x200; buffer ends tagged 0x200.
- `invalidate` pulsed during HIGH_WAIT of a fill for 0x300 → buffer not written; re-presenting 0x300 refetches both halves.
- Reset asserted during LOW_WAIT with a late `mem_readdatavalid` after release → ignored; state IDLE, `buf_valid` = 0.
